// File: rtl/rom_fetch_scheduler.sv
// Fetch sequencer / time-slice scheduler between CPU fetch stage and instruction ROM.
// Optional quantum preemption is built when ROM_SCHED_PREEMPT_EN is defined.
module rom_fetch_scheduler #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int REGION_SIZE = 200,
  parameter int NUM_PROGS   = 2,
  parameter int QUANTUM     = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         fetch_req,
  input  logic [ADDR_WIDTH-1:0]        fetch_off,
  output logic                         fetch_valid,
  output logic [DATA_WIDTH-1:0]        fetch_instr,
  output logic [ADDR_WIDTH-1:0]        rom_addr,
  input  logic [DATA_WIDTH-1:0]        rom_q,
  input  logic                         syscall,
  input  logic                         os_done,
  input  logic                         yield,
  input  logic                         ctx_done,
  output logic [1:0]                   mode,
  output logic [$clog2(NUM_PROGS)-1:0] cur_prog,
  output logic                         preempt,
  output logic                         fault
);

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_PROG = 2'd1,
    MODE_CTX  = 2'd2,
    MODE_OS   = 2'd3
  } mode_e;

  localparam int                    PW        = $clog2(NUM_PROGS);
  localparam logic [ADDR_WIDTH-1:0] REGION_W  = ADDR_WIDTH'(REGION_SIZE);
  localparam logic [PW-1:0]         LAST_PROG = PW'(NUM_PROGS - 1);

  if (NUM_PROGS < 2 || QUANTUM < 1) begin : g_bad_cfg
    $error("rom_fetch_scheduler: NUM_PROGS must be >= 2 and QUANTUM >= 1");
  end

  mode_e                 mode_r, mode_nxt_s;
  logic [PW-1:0]         cur_prog_r, cur_prog_nxt_s;
  logic                  fetch_valid_r;
  logic                  preempt_r, preempt_nxt_s;
  logic                  fault_r, fault_nxt_s;
  logic                  pending_r, pending_nxt_s;
  logic                  accept_s, bad_off_s, expiry_s;
  logic [ADDR_WIDTH-1:0] base_s;

  // Fetch classification and region base for the current mode
  always_comb begin
    accept_s  = 1'b0;
    bad_off_s = 1'b0;
    if (fetch_req && (mode_r != MODE_IDLE)) begin
      accept_s  = (fetch_off < REGION_W);
      bad_off_s = (fetch_off >= REGION_W);
    end else begin
      accept_s  = 1'b0;
      bad_off_s = 1'b0;
    end
    case (mode_r)
      MODE_CTX:  base_s = {ADDR_WIDTH{1'b0}};
      MODE_OS:   base_s = REGION_W;
      MODE_PROG: base_s = (ADDR_WIDTH'(cur_prog_r) + ADDR_WIDTH'(2)) * REGION_W;
      default:   base_s = {ADDR_WIDTH{1'b0}};
    endcase
  end

  assign rom_addr    = accept_s ? (base_s + fetch_off) : {ADDR_WIDTH{1'b0}};
  assign fetch_valid = fetch_valid_r;
  // ROM data arrives one cycle after the address, aligned with fetch_valid
  assign fetch_instr = fetch_valid_r ? rom_q : {DATA_WIDTH{1'b0}};
  assign mode        = mode_r;
  assign cur_prog    = cur_prog_r;
  assign preempt     = preempt_r;
  assign fault       = fault_r;

`ifdef ROM_SCHED_PREEMPT_EN
  localparam int QW = $clog2(QUANTUM + 1);
  logic [QW-1:0] qcnt_r;
  logic          reload_s;

  // Counter saturates at zero so a late re-entry to PROG cannot wrap it
  assign expiry_s = accept_s && (mode_r == MODE_PROG) && (qcnt_r <= QW'(1));
  assign reload_s = (mode_r == MODE_CTX) && ctx_done && !bad_off_s;

  // Time-slice counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qcnt_r <= QW'(QUANTUM);
    end else if (reload_s) begin
      qcnt_r <= QW'(QUANTUM);
    end else if (accept_s && (mode_r == MODE_PROG) && (qcnt_r != QW'(0))) begin
      qcnt_r <= qcnt_r - QW'(1);
    end else begin
      qcnt_r <= qcnt_r;
    end
  end
`else
  assign expiry_s = 1'b0;
`endif

  // Next-state, program rotation and event pulses
  always_comb begin
    mode_nxt_s     = mode_r;
    cur_prog_nxt_s = cur_prog_r;
    pending_nxt_s  = pending_r;
    preempt_nxt_s  = 1'b0;
    fault_nxt_s    = 1'b0;
    if (bad_off_s) begin
      mode_nxt_s    = MODE_OS;
      fault_nxt_s   = 1'b1;
      pending_nxt_s = 1'b0;
    end else begin
      case (mode_r)
        MODE_IDLE: begin
          if (start) mode_nxt_s = MODE_OS;
          else       mode_nxt_s = MODE_IDLE;
        end
        MODE_OS: begin
          if (os_done && pending_r) begin
            mode_nxt_s    = MODE_CTX;
            pending_nxt_s = 1'b0;
            preempt_nxt_s = 1'b1;
          end else if (os_done) begin
            mode_nxt_s = MODE_PROG;
          end else begin
            mode_nxt_s = MODE_OS;
          end
        end
        MODE_PROG: begin
          if (syscall) begin
            mode_nxt_s    = MODE_OS;
            pending_nxt_s = pending_r | expiry_s;
          end else if (yield) begin
            mode_nxt_s = MODE_CTX;
          end else if (expiry_s) begin
            mode_nxt_s    = MODE_CTX;
            preempt_nxt_s = 1'b1;
          end else begin
            mode_nxt_s = MODE_PROG;
          end
        end
        MODE_CTX: begin
          if (ctx_done) begin
            mode_nxt_s     = MODE_PROG;
            cur_prog_nxt_s = (cur_prog_r == LAST_PROG) ? {PW{1'b0}} : cur_prog_r + PW'(1);
          end else begin
            mode_nxt_s = MODE_CTX;
          end
        end
        default: mode_nxt_s = MODE_IDLE;
      endcase
    end
  end

  // Scheduler state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r        <= MODE_IDLE;
      cur_prog_r    <= {PW{1'b0}};
      pending_r     <= 1'b0;
      preempt_r     <= 1'b0;
      fault_r       <= 1'b0;
      fetch_valid_r <= 1'b0;
    end else begin
      mode_r        <= mode_nxt_s;
      cur_prog_r    <= cur_prog_nxt_s;
      pending_r     <= pending_nxt_s;
      preempt_r     <= preempt_nxt_s;
      fault_r       <= fault_nxt_s;
      fetch_valid_r <= accept_s;
    end
  end

endmodule

// File: tb/tb_rom_fetch_scheduler.sv
// Directed self-checking bench for rom_fetch_scheduler (REGION_SIZE 200, 2 programs, QUANTUM 4).
// Preemption scenarios run when ROM_SCHED_PREEMPT_EN is defined; otherwise the no-preempt scenario runs.
module tb_rom_fetch_scheduler;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RS = 200;
  localparam int NP = 2;
  localparam int QT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, fetch_req = 1'b0;
  logic          syscall = 1'b0, os_done = 1'b0, yield = 1'b0, ctx_done = 1'b0;
  logic [AW-1:0] fetch_off = '0;
  logic [DW-1:0] rom_q = '0;
  logic          fetch_valid, preempt, fault;
  logic [DW-1:0] fetch_instr;
  logic [AW-1:0] rom_addr;
  logic [1:0]    mode;
  logic [0:0]    cur_prog;
  int            checks = 0;
  int            errors = 0;

  rom_fetch_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REGION_SIZE(RS), .NUM_PROGS(NP), .QUANTUM(QT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .fetch_req(fetch_req), .fetch_off(fetch_off),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .rom_addr(rom_addr), .rom_q(rom_q),
    .syscall(syscall), .os_done(os_done), .yield(yield), .ctx_done(ctx_done),
    .mode(mode), .cur_prog(cur_prog), .preempt(preempt), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Synchronous ROM model with one-cycle read latency
  always @(posedge clk) rom_q <= rom_word(rom_addr);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    checks++; if (cur_prog !== 1'b0) begin errors++; $display("FAIL reset_cur_prog: got %0d expected 0", cur_prog); end
    checks++; if (fetch_valid !== 1'b0 || fetch_instr !== 32'h0) begin errors++; $display("FAIL reset_fetch: got valid=%0b instr=%h expected 0/0", fetch_valid, fetch_instr); end
    checks++; if (preempt !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_pulses: got preempt=%0b fault=%0b expected 0/0", preempt, fault); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_idle_ignore();
    fetch_req = 1'b1; fetch_off = 32'd5;
    #1;
    checks++; if (rom_addr !== 32'd0) begin errors++; $display("FAIL idle_rom_addr: got %0d expected 0", rom_addr); end
    cyc();
    fetch_off = 32'd250;
    #1;
    cyc();
    fetch_req = 1'b0;
    checks++; if (fetch_valid !== 1'b0 || fault !== 1'b0 || mode !== 2'd0) begin errors++; $display("FAIL idle_ignore: got valid=%0b fault=%0b mode=%0d expected 0/0/0", fetch_valid, fault, mode); end
  endtask

  task automatic test_boot();
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (mode !== 2'd3) begin errors++; $display("FAIL boot_mode_os: got %0d expected 3", mode); end
    fetch_req = 1'b1; fetch_off = 32'd7;
    #1;
    checks++; if (rom_addr !== 32'd207) begin errors++; $display("FAIL os_rom_addr: got %0d expected 207", rom_addr); end
    cyc(); fetch_req = 1'b0;
    checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'hC0DE_00CF) begin errors++; $display("FAIL os_fetch_data: got valid=%0b instr=%h expected 1/c0de00cf", fetch_valid, fetch_instr); end
    cyc();
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle: got %0b expected 0", fetch_valid); end
    os_done = 1'b1; cyc(); os_done = 1'b0;
    checks++; if (mode !== 2'd1 || cur_prog !== 1'b0) begin errors++; $display("FAIL boot_prog: got mode=%0d prog=%0d expected 1/0", mode, cur_prog); end
    fetch_req = 1'b1; fetch_off = 32'd5;
    #1;
    checks++; if (rom_addr !== 32'd405) begin errors++; $display("FAIL prog0_rom_addr: got %0d expected 405", rom_addr); end
    cyc(); fetch_req = 1'b0;
    checks++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'hC0DE_0195) begin errors++; $display("FAIL prog0_fetch_data: got valid=%0b instr=%h expected 1/c0de0195", fetch_valid, fetch_instr); end
  endtask

  task automatic test_fault();
    fetch_req = 1'b1; fetch_off = 32'd200;
    #1;
    checks++; if (rom_addr !== 32'd0) begin errors++; $display("FAIL fault_rom_addr: got %0d expected 0", rom_addr); end
    cyc(); fetch_req = 1'b0;
    checks++; if (fault !== 1'b1 || mode !== 2'd3 || fetch_valid !== 1'b0) begin errors++; $display("FAIL fault_entry: got fault=%0b mode=%0d valid=%0b expected 1/3/0", fault, mode, fetch_valid); end
    cyc();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_one_cycle: got %0b expected 0", fault); end
    os_done = 1'b1; cyc(); os_done = 1'b0;
    checks++; if (mode !== 2'd1 || preempt !== 1'b0) begin errors++; $display("FAIL fault_resume: got mode=%0d preempt=%0b expected 1/0", mode, preempt); end
  endtask

  task automatic test_yield_wrap();
    syscall = 1'b0;
    start = 1'b1; os_done = 1'b1; ctx_done = 1'b1; cyc();
    start = 1'b0; os_done = 1'b0; ctx_done = 1'b0;
    checks++; if (mode !== 2'd1) begin errors++; $display("FAIL prog_ignore_pulses: got mode %0d expected 1", mode); end
    yield = 1'b1; cyc(); yield = 1'b0;
    checks++; if (mode !== 2'd2 || preempt !== 1'b0) begin errors++; $display("FAIL yield_ctx: got mode=%0d preempt=%0b expected 2/0", mode, preempt); end
    fetch_req = 1'b1; fetch_off = 32'd9;
    #1;
    checks++; if (rom_addr !== 32'd9) begin errors++; $display("FAIL ctx_rom_addr: got %0d expected 9", rom_addr); end
    cyc(); fetch_req = 1'b0;
    ctx_done = 1'b1; cyc(); ctx_done = 1'b0;
    checks++; if (mode !== 2'd1 || cur_prog !== 1'b1) begin errors++; $display("FAIL ctx_to_prog1: got mode=%0d prog=%0d expected 1/1", mode, cur_prog); end
    fetch_req = 1'b1; fetch_off = 32'd0; yield = 1'b1;
    #1;
    checks++; if (rom_addr !== 32'd600) begin errors++; $display("FAIL prog1_rom_addr: got %0d expected 600", rom_addr); end
    cyc(); fetch_req = 1'b0; yield = 1'b0;
    checks++; if (mode !== 2'd2 || fetch_valid !== 1'b1 || fetch_instr !== 32'hC0DE_0258) begin errors++; $display("FAIL fetch_across_switch: got mode=%0d valid=%0b instr=%h expected 2/1/c0de0258", mode, fetch_valid, fetch_instr); end
    os_done = 1'b1; syscall = 1'b1; start = 1'b1; cyc();
    os_done = 1'b0; syscall = 1'b0; start = 1'b0;
    checks++; if (mode !== 2'd2) begin errors++; $display("FAIL ctx_ignore_pulses: got mode %0d expected 2", mode); end
    ctx_done = 1'b1; cyc(); ctx_done = 1'b0;
    checks++; if (mode !== 2'd1 || cur_prog !== 1'b0) begin errors++; $display("FAIL prog_wrap: got mode=%0d prog=%0d expected 1/0", mode, cur_prog); end
  endtask

`ifdef ROM_SCHED_PREEMPT_EN
  task automatic test_preempt();
    logic [AW-1:0] off;
    for (int i = 0; i < 4; i++) begin
      off = AW'(10 + i);
      fetch_req = 1'b1; fetch_off = off;
      #1;
      checks++; if (rom_addr !== 32'd400 + off) begin errors++; $display("FAIL b2b_rom_addr[%0d]: got %0d expected %0d", i, rom_addr, 32'd400 + off); end
      cyc();
      checks++; if (fetch_valid !== 1'b1 || fetch_instr !== rom_word(32'd400 + off)) begin errors++; $display("FAIL b2b_data[%0d]: got valid=%0b instr=%h", i, fetch_valid, fetch_instr); end
      if (i < 3) begin
        checks++; if (mode !== 2'd1 || preempt !== 1'b0) begin errors++; $display("FAIL pre_expiry[%0d]: got mode=%0d preempt=%0b expected 1/0", i, mode, preempt); end
      end else begin
        checks++; if (mode !== 2'd2 || preempt !== 1'b1) begin errors++; $display("FAIL expiry: got mode=%0d preempt=%0b expected 2/1", mode, preempt); end
      end
    end
    fetch_off = 32'd3;
    #1;
    checks++; if (rom_addr !== 32'd3) begin errors++; $display("FAIL preempt_ctx_addr: got %0d expected 3", rom_addr); end
    cyc(); fetch_req = 1'b0;
    checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL preempt_one_cycle: got %0b expected 0", preempt); end
    ctx_done = 1'b1; cyc(); ctx_done = 1'b0;
    fetch_req = 1'b1; fetch_off = 32'd0;
    #1;
    checks++; if (mode !== 2'd1 || cur_prog !== 1'b1 || rom_addr !== 32'd600) begin errors++; $display("FAIL preempt_resume: got mode=%0d prog=%0d addr=%0d expected 1/1/600", mode, cur_prog, rom_addr); end
    cyc(); fetch_req = 1'b0;
  endtask

  task automatic test_syscall_expiry();
    fetch_req = 1'b1;
    fetch_off = 32'd1; cyc();
    fetch_off = 32'd2; cyc();
    fetch_off = 32'd3; syscall = 1'b1;
    #1;
    checks++; if (rom_addr !== 32'd603) begin errors++; $display("FAIL sys_exp_addr: got %0d expected 603", rom_addr); end
    cyc(); fetch_req = 1'b0; syscall = 1'b0;
    checks++; if (mode !== 2'd3 || preempt !== 1'b0) begin errors++; $display("FAIL sys_exp_os: got mode=%0d preempt=%0b expected 3/0", mode, preempt); end
    os_done = 1'b1; cyc(); os_done = 1'b0;
    checks++; if (mode !== 2'd2 || preempt !== 1'b1) begin errors++; $display("FAIL pending_preempt: got mode=%0d preempt=%0b expected 2/1", mode, preempt); end
    cyc();
    checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL pending_one_cycle: got %0b expected 0", preempt); end
    ctx_done = 1'b1; cyc(); ctx_done = 1'b0;
    checks++; if (mode !== 2'd1 || cur_prog !== 1'b0) begin errors++; $display("FAIL sys_exp_resume: got mode=%0d prog=%0d expected 1/0", mode, cur_prog); end
  endtask

  task automatic test_yield_expiry();
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_off = AW'(i); cyc();
    end
    fetch_off = 32'd3; yield = 1'b1; cyc();
    fetch_req = 1'b0; yield = 1'b0;
    checks++; if (mode !== 2'd2 || preempt !== 1'b0) begin errors++; $display("FAIL yield_expiry: got mode=%0d preempt=%0b expected 2/0", mode, preempt); end
    ctx_done = 1'b1; cyc(); ctx_done = 1'b0;
    checks++; if (mode !== 2'd1 || cur_prog !== 1'b1 || preempt !== 1'b0) begin errors++; $display("FAIL yield_exp_resume: got mode=%0d prog=%0d preempt=%0b expected 1/1/0", mode, cur_prog, preempt); end
  endtask
`else
  task automatic test_no_preempt();
    logic [AW-1:0] off;
    for (int i = 0; i < 100; i++) begin
      off = AW'(2 * i);
      fetch_req = 1'b1; fetch_off = off;
      #1;
      checks++; if (rom_addr !== 32'd400 + off) begin errors++; $display("FAIL np_rom_addr[%0d]: got %0d expected %0d", i, rom_addr, 32'd400 + off); end
      cyc();
      checks++; if (mode !== 2'd1 || preempt !== 1'b0 || fetch_valid !== 1'b1 || fetch_instr !== rom_word(32'd400 + off)) begin errors++; $display("FAIL np_state[%0d]: got mode=%0d preempt=%0b valid=%0b instr=%h", i, mode, preempt, fetch_valid, fetch_instr); end
    end
    fetch_req = 1'b0;
    yield = 1'b1; cyc(); yield = 1'b0;
    ctx_done = 1'b1; cyc(); ctx_done = 1'b0;
    checks++; if (mode !== 2'd1 || cur_prog !== 1'b1) begin errors++; $display("FAIL np_to_prog1: got mode=%0d prog=%0d expected 1/1", mode, cur_prog); end
  endtask
`endif

  task automatic test_reset_inflight();
    fetch_req = 1'b1; fetch_off = 32'd4;
    cyc(); fetch_req = 1'b0;
    checks++; if (fetch_valid !== 1'b1 || cur_prog !== 1'b1) begin errors++; $display("FAIL pre_async_rst: got valid=%0b prog=%0d expected 1/1", fetch_valid, cur_prog); end
    rst = 1'b1;
    #1;
    checks++; if (fetch_valid !== 1'b0 || fetch_instr !== 32'h0 || mode !== 2'd0 || cur_prog !== 1'b0) begin errors++; $display("FAIL async_rst: got valid=%0b instr=%h mode=%0d prog=%0d expected 0/0/0/0", fetch_valid, fetch_instr, mode, cur_prog); end
    cyc(); rst = 1'b0; cyc();
    start = 1'b1; cyc(); start = 1'b0;
    os_done = 1'b1; cyc(); os_done = 1'b0;
    fetch_req = 1'b1; fetch_off = 32'd20;
    #1;
    checks++; if (rom_addr !== 32'd420) begin errors++; $display("FAIL inflight_addr: got %0d expected 420", rom_addr); end
    rst = 1'b1;
    #1;
    checks++; if (rom_addr !== 32'd0 || mode !== 2'd0) begin errors++; $display("FAIL rst_addr: got addr=%0d mode=%0d expected 0/0", rom_addr, mode); end
    cyc(); fetch_req = 1'b0;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL inflight_discard: got %0b expected 0", fetch_valid); end
    rst = 1'b0; cyc();
    checks++; if (fetch_valid !== 1'b0 || mode !== 2'd0 || preempt !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL post_rst: got valid=%0b mode=%0d preempt=%0b fault=%0b expected 0/0/0/0", fetch_valid, mode, preempt, fault); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_ignore();
    test_boot();
    test_fault();
    test_yield_wrap();
`ifdef ROM_SCHED_PREEMPT_EN
    test_preempt();
    test_syscall_expiry();
    test_yield_expiry();
`else
    test_no_preempt();
`endif
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_fetch_scheduler.md
# rom_fetch_scheduler

Fetch sequencer and time-slice scheduler placed between the processor's fetch stage and the synchronous instruction ROM. The ROM is partitioned into fixed regions: context-switch routine, operating system, then one region per user program. The block translates region-relative fetch offsets into absolute ROM addresses and tracks which region is active. It preempts user programs on quantum expiry and moves execution between program, OS and context-switch regions on handshake pulses from the CPU.

## Interface
- ADDR_WIDTH, 32, ROM address width
- DATA_WIDTH, 32, instruction width
- REGION_SIZE, 200, words per region
- NUM_PROGS, 2, user programs (≥2); program k occupies base (2+k)*REGION_SIZE
- QUANTUM, 64, accepted fetches per time slice (≥1)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  boot pulse, honoured only in IDLE
- fetch_req  in  1  CPU fetch request
- fetch_off  in  ADDR_WIDTH  offset within the active region
- fetch_valid  out  1  instruction valid, registered
- fetch_instr  out  DATA_WIDTH  instruction returned to CPU
- rom_addr  out  ADDR_WIDTH  absolute ROM address, combinational
- rom_q  in  DATA_WIDTH  ROM read data, 1-cycle latency
- syscall  in  1  pulse: enter OS
- os_done  in  1  pulse: leave OS
- yield  in  1  pulse: voluntary context switch
- ctx_done  in  1  pulse: context-switch routine finished
- mode  out  2  0 IDLE, 1 PROG, 2 CTX, 3 OS
- cur_prog  out  $clog2(NUM_PROGS)  active program index
- preempt  out  1  one-cycle pulse on quantum-driven entry to CTX
- fault  out  1  one-cycle pulse on out-of-range offset

## Operation
- Region base by mode: CTX 0, OS REGION_SIZE, PROG (2+cur_prog)*REGION_SIZE. rom_addr = base + fetch_off, unsigned, truncated to ADDR_WIDTH. rom_addr = 0 when no fetch is accepted.
- A fetch is accepted when fetch_req=1, mode≠IDLE and fetch_off < REGION_SIZE.
- fetch_req=1 with fetch_off ≥ REGION_SIZE: no ROM access, no fetch_valid, fault pulses next cycle, and mode goes to OS. The pending-preempt flag is cleared.
- Fetch requests in IDLE are ignored silently.
- State transitions:
  - IDLE: start → OS.
  - OS: os_done → PROG, or → CTX if the pending-preempt flag is set (flag cleared, preempt pulses).
  - PROG: syscall → OS; yield → CTX; quantum expiry → CTX with preempt pulse.
  - CTX: ctx_done → PROG with cur_prog = (cur_prog+1) mod NUM_PROGS and the quantum reloaded.
- Quantum counter: decrements on each accepted fetch in PROG. An accepted fetch at count 1 causes expiry; the transition to CTX occurs on the following edge. The counter holds in OS and CTX.
- Priority in PROG, same cycle: syscall > yield > expiry.
  - syscall with expiry: enter OS and set the pending-preempt flag.
  - yield with expiry: a single transition to CTX, no preempt pulse.
- Handshake pulses that are not valid in the current mode are ignored.
- Reset values (asynchronous, immediate): mode IDLE, cur_prog 0, counter QUANTUM, pending flag 0. fetch_valid, fetch_instr, preempt and fault all 0. An in-flight fetch is discarded.

## Timing
- Fetch accepted in cycle N: rom_addr is presented in N. fetch_valid=1 and fetch_instr=rom_q in cycle N+1, for exactly one cycle.
- A fetch accepted in the same cycle as a mode change still completes at N+1 using the address computed from the old mode.
- Back-to-back fetches: one per cycle, full throughput.
- Mode change, cur_prog update, preempt and fault are all visible the cycle after the triggering edge.

## Configuration
- ROM_SCHED_PREEMPT_EN:
  - Defined: quantum counter, expiry, the pending-preempt flag and preempt are active.
  - Undefined: no counter is built, preempt is tied to 0, and programs leave PROG only via syscall, yield or fault.

## Test plan
- Boot: rst, then start → mode 3. os_done → mode 1, cur_prog 0. Fetch with offset 5 → rom_addr 405; instr valid the next cycle.
- Preemption (QUANTUM=4, EN defined): 4 back-to-back fetches → preempt pulse, mode 2, rom_addr = offset. ctx_done → mode 1, cur_prog 1, fetch offset 0 → rom_addr 600.
- Syscall coincident with expiry fetch → mode 3. os_done → mode 2 with preempt pulse.
- Fault: fetch_off 200 in PROG → no fetch_valid, fault pulse, mode 3.
- Wrap: cur_prog 1, yield, ctx_done → cur_prog 0. Issue rst during an in-flight fetch → fetch_valid stays 0 and all outputs reset.
- EN undefined: 100 fetches in PROG → mode stays 1, preempt never asserted.
